// File: rtl/input_reader_sync.sv
// ---------------------------------------------------------------------------
// input_reader_sync
// Operand front end for the adder datapath. Every raw board input (2*WIDTH
// slide switches, carry button Btn0, capture button BtnLoad) passes a 2-flop
// synchroniser and an independent per-bit debouncer. The debounced values
// drive the registered operands InputX/InputY and carry-in Cin, either live
// (LOAD_MODE=0) or captured on a debounced BtnLoad press (LOAD_MODE=1).
// Valid pulses for one cycle whenever a new operand set is presented.
//
// Ports
//   Clk      in   system clock, rising edge
//   Rst_n    in   asynchronous active-low reset
//   Sw       in   raw switches, [WIDTH-1:0] -> X, [2*WIDTH-1:WIDTH] -> Y
//   Btn0     in   raw carry button
//   BtnLoad  in   raw capture button, active-high (unused when LOAD_MODE=0)
//   InputX   out  registered operand X
//   InputY   out  registered operand Y
//   Cin      out  registered carry-in
//   Valid    out  one-cycle pulse with each new operand set
//
// Debounce FSM (one instance per input bit)
//   state       | meaning
//   ST_STABLE   | synchronised input equals debounced value, counter idle
//   ST_COUNTING | input differs from debounced value, counting stable cycles
// ---------------------------------------------------------------------------
module input_reader_sync #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CIN_ACTIVE_LOW  = 1,
  parameter int LOAD_MODE       = 1
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [2*WIDTH-1:0] Sw,
  input  logic               Btn0,
  input  logic               BtnLoad,
  output logic [WIDTH-1:0]   InputX,
  output logic [WIDTH-1:0]   InputY,
  output logic               Cin,
  output logic               Valid
);

  // Bit layout of the debounced vector: {BtnLoad, Btn0, Sw}
  localparam int NB      = 2*WIDTH + 2;
  localparam int B_BTN0  = 2*WIDTH;
  localparam int B_LOAD  = 2*WIDTH + 1;
  localparam int CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Btn0 resets to its released level so Cin starts deasserted.
  localparam logic [NB-1:0] DEB_RST  = {1'b0, (CIN_ACTIVE_LOW != 0), {(2*WIDTH){1'b0}}};

  typedef enum logic {ST_STABLE = 1'b0, ST_COUNTING = 1'b1} db_state_e;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1_q, sync2_q;
  db_state_e     state_q [NB];
  db_state_e     state_d [NB];
  logic [CW-1:0] cnt_q   [NB];
  logic [CW-1:0] cnt_d   [NB];
  logic [NB-1:0] deb_q, deb_d;
  logic [NB-1:0] deb_dly_q;

  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic             cin_q, cin_d, valid_q, valid_d;
  logic             carry_now, carry_dly, load_evt;

  assign raw = {BtnLoad, Btn0, Sw};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM: state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NB; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
      deb_q     <= DEB_RST;
      deb_dly_q <= DEB_RST;
    end else begin
      for (int i = 0; i < NB; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
    end
  end

  // Debounce FSM: next state
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        ST_STABLE: begin
          // A single-cycle debounce accepts the change straight from STABLE.
          if (sync2_q[i] != deb_q[i] && DEBOUNCE_CYCLES > 1) state_d[i] = ST_COUNTING;
        end
        ST_COUNTING: begin
          if (sync2_q[i] == deb_q[i] || cnt_q[i] == CNT_LAST) state_d[i] = ST_STABLE;
        end
      endcase
    end
  end

  // Debounce FSM: counter and debounced value
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      unique case (state_q[i])
        ST_STABLE: begin
          if (sync2_q[i] != deb_q[i]) begin
            if (DEBOUNCE_CYCLES == 1) deb_d[i] = sync2_q[i];
            else                      cnt_d[i] = CW'(1);
          end
        end
        ST_COUNTING: begin
          if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) deb_d[i] = sync2_q[i];
            else                      cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      endcase
    end
  end

  assign carry_now = (CIN_ACTIVE_LOW != 0) ? ~deb_q[B_BTN0]     : deb_q[B_BTN0];
  assign carry_dly = (CIN_ACTIVE_LOW != 0) ? ~deb_dly_q[B_BTN0] : deb_dly_q[B_BTN0];
  assign load_evt  = deb_q[B_LOAD] & ~deb_dly_q[B_LOAD];

  // Captures take the delayed debounced copy: a switch that finishes
  // debouncing on the same edge as BtnLoad is not yet visible to the press.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    cin_d   = cin_q;
    valid_d = 1'b0;
    if (LOAD_MODE != 0) begin
      if (load_evt) begin
        x_d     = deb_dly_q[WIDTH-1:0];
        y_d     = deb_dly_q[2*WIDTH-1:WIDTH];
        cin_d   = carry_dly;
        valid_d = 1'b1;
      end
    end else begin
      x_d     = deb_q[WIDTH-1:0];
      y_d     = deb_q[2*WIDTH-1:WIDTH];
      cin_d   = carry_now;
      valid_d = ({x_d, y_d, cin_d} != {x_q, y_q, cin_q});
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      cin_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      cin_q   <= cin_d;
      valid_q <= valid_d;
    end
  end

  assign InputX = x_q;
  assign InputY = y_q;
  assign Cin    = cin_q;
  assign Valid  = valid_q;

endmodule

// File: tb/tb_input_reader_sync.sv
// Bench for input_reader_sync: one live-tracking instance (LOAD_MODE=0) and
// one press-capture instance (LOAD_MODE=1) share the same raw inputs. The
// reference model accepts a bit change once the last DEBOUNCE_CYCLES
// synchronised samples all disagree with the current debounced value.
module tb_input_reader_sync;
  localparam int D = 4;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b1;
  logic [7:0] sw;
  logic       btn0, btnload;
  logic [3:0] x0, y0, x1, y1;
  logic       c0, v0, c1, v1;

  int checks = 0;
  int errors = 0;
  int vcnt0 = 0;
  int vcnt1 = 0;

  // model state; vector layout {BtnLoad, Btn0, Sw}
  logic [9:0] raw_hist[$];
  logic [9:0] sync_hist[$];
  logic [9:0] m_deb, m_dly;
  logic [3:0] mx0, my0, mx1, my1;
  logic       mc0, mv0, mc1, mv1;

  always #5 Clk = ~Clk;

  input_reader_sync #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .CIN_ACTIVE_LOW(1), .LOAD_MODE(0)) dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .Sw(sw), .Btn0(btn0), .BtnLoad(btnload),
    .InputX(x0), .InputY(y0), .Cin(c0), .Valid(v0));

  input_reader_sync #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .CIN_ACTIVE_LOW(1), .LOAD_MODE(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .Sw(sw), .Btn0(btn0), .BtnLoad(btnload),
    .InputX(x1), .InputY(y1), .Cin(c1), .Valid(v1));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    raw_hist.delete();
    sync_hist.delete();
    m_deb = 10'h100;
    m_dly = 10'h100;
    mx0 = '0; my0 = '0; mc0 = 1'b0; mv0 = 1'b0;
    mx1 = '0; my1 = '0; mc1 = 1'b0; mv1 = 1'b0;
  endfunction

  // One rising edge with 'raw' present at the pins.
  function automatic void model_edge(input logic [9:0] raw);
    logic [9:0] s, deb_old, dly_old, deb_new;
    logic [8:0] o0;
    bit         flip;
    s = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 10'h000;
    raw_hist.push_back(raw);
    if (raw_hist.size() > 2) void'(raw_hist.pop_front());
    sync_hist.push_back(s);
    if (sync_hist.size() > D) void'(sync_hist.pop_front());
    deb_old = m_deb;
    dly_old = m_dly;
    deb_new = deb_old;
    if (sync_hist.size() == D) begin
      for (int b = 0; b < 10; b++) begin
        flip = 1'b1;
        foreach (sync_hist[j]) if (sync_hist[j][b] == deb_old[b]) flip = 1'b0;
        if (flip) deb_new[b] = ~deb_old[b];
      end
    end
    o0  = {deb_old[7:4], deb_old[3:0], ~deb_old[8]};
    mv0 = (o0 != {my0, mx0, mc0});
    {my0, mx0, mc0} = o0;
    mv1 = deb_old[9] & ~dly_old[9];
    if (mv1) begin
      mx1 = dly_old[3:0];
      my1 = dly_old[7:4];
      mc1 = ~dly_old[8];
    end
    m_dly = deb_old;
    m_deb = deb_new;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      if (Rst_n) model_edge({btnload, btn0, sw});
      @(negedge Clk);
      if (Rst_n) begin
        chk("m_x0", 16'(x0), 16'(mx0));
        chk("m_y0", 16'(y0), 16'(my0));
        chk("m_c0", 16'(c0), 16'(mc0));
        chk("m_v0", 16'(v0), 16'(mv0));
        chk("m_x1", 16'(x1), 16'(mx1));
        chk("m_y1", 16'(y1), 16'(my1));
        chk("m_c1", 16'(c1), 16'(mc1));
        chk("m_v1", 16'(v1), 16'(mv1));
        vcnt0 += int'(v0);
        vcnt1 += int'(v1);
      end
    end
  endtask

  // Assert reset away from a clock edge and check outputs clear at once.
  task automatic rst_assert();
    Rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_x0", 16'(x0), 16'h0);
    chk("rst_y0", 16'(y0), 16'h0);
    chk("rst_c0", 16'(c0), 16'h0);
    chk("rst_v0", 16'(v0), 16'h0);
    chk("rst_x1", 16'(x1), 16'h0);
    chk("rst_y1", 16'(y1), 16'h0);
    chk("rst_c1", 16'(c1), 16'h0);
    chk("rst_v1", 16'(v1), 16'h0);
  endtask

  initial begin
    sw = 8'hFF; btn0 = 1'b1; btnload = 1'b0;

    // reset with switches all high, before any clock edge
    #2;
    rst_assert();
    sw = 8'h00;
    step(2);
    Rst_n = 1'b1;
    step(10);

    // live tracking latency
    sw = 8'h3A;
    vcnt0 = 0;
    step(6);
    chk("t2_v_early", 16'(v0), 16'h0);
    chk("t2_x_early", 16'(x0), 16'h0);
    step(1);
    chk("t2_v", 16'(v0), 16'h1);
    chk("t2_x", 16'(x0), 16'hA);
    chk("t2_y", 16'(y0), 16'h3);
    step(1);
    chk("t2_v_after", 16'(v0), 16'h0);
    chk("t2_vcnt", 16'(vcnt0), 16'h1);

    // bounce on Sw[0]
    vcnt0 = 0;
    sw[0] = 1'b1; step(1);
    sw[0] = 1'b0; step(1);
    sw[0] = 1'b1; step(1);
    sw[0] = 1'b0; step(10);
    chk("t3_vcnt", 16'(vcnt0), 16'h0);
    chk("t3_x", 16'(x0), 16'hA);

    // capture on held press
    sw = 8'h5C; btn0 = 1'b0;
    step(10);
    vcnt1 = 0;
    btnload = 1'b1;
    step(20);
    chk("t4_vcnt", 16'(vcnt1), 16'h1);
    chk("t4_x", 16'(x1), 16'hC);
    chk("t4_y", 16'(y1), 16'h5);
    chk("t4_c", 16'(c1), 16'h1);
    btnload = 1'b0;
    step(10);
    sw = 8'h00;
    vcnt1 = 0;
    step(15);
    chk("t4_hold_vcnt", 16'(vcnt1), 16'h0);
    chk("t4_hold_x", 16'(x1), 16'hC);
    chk("t4_hold_y", 16'(y1), 16'h5);

    // press and switch change finishing debounce on the same edge
    sw = 8'h5C;
    step(12);
    vcnt1 = 0;
    sw = 8'h11; btnload = 1'b1;
    step(12);
    chk("t5_vcnt", 16'(vcnt1), 16'h1);
    chk("t5_x_old", 16'(x1), 16'hC);
    chk("t5_y_old", 16'(y1), 16'h5);
    btnload = 1'b0;
    step(10);
    vcnt1 = 0;
    btnload = 1'b1;
    step(12);
    chk("t5_vcnt2", 16'(vcnt1), 16'h1);
    chk("t5_x_new", 16'(x1), 16'h1);
    chk("t5_y_new", 16'(y1), 16'h1);
    btnload = 1'b0;
    step(10);

    // reset two cycles into a switch change
    btn0 = 1'b1;
    step(10);
    sw = 8'h96;
    step(2);
    rst_assert();
    step(2);
    Rst_n = 1'b1;
    vcnt0 = 0;
    step(6);
    chk("t6_v_early", 16'(v0), 16'h0);
    chk("t6_vcnt", 16'(vcnt0), 16'h0);
    step(1);
    chk("t6_v", 16'(v0), 16'h1);
    chk("t6_x", 16'(x0), 16'h6);
    chk("t6_y", 16'(y0), 16'h9);
    chk("t6_c", 16'(c0), 16'h0);

    // randomized holds, short ones act as bounces
    for (int r = 0; r < 80; r++) begin
      sw      = 8'($urandom);
      btn0    = 1'($urandom_range(0, 1));
      btnload = ($urandom_range(0, 2) == 0);
      step($urandom_range(1, 9));
      if (r == 40) begin
        rst_assert();
        step(1);
        Rst_n = 1'b1;
      end
    end
    step(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
